// File: rtl/pll_rst_pkg.sv
// Shared state encoding and sizing helper for the PLL reset sequencer.
package pll_rst_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Width of a counter that must hold the larger of the two window lengths.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; resets to 0.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // CDC: meta is the first capture stage; constrain d -> meta as an async crossing.
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock into a qualified, synchronously released system reset.
// Optional lock-loss event counter enabled by defining PLL_RST_SEQ_LOSS_COUNT_EN.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES        = 16,
    parameter int unsigned LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    output logic                  sys_rst,
    output logic                  ready,
    output logic [STATE_W-1:0]    state_o,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Sequencer; sys_rst/ready are registered alongside the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            case (state)
                ST_WAIT_LOCK: begin
                    cnt <= '0;
                    if (lock_s) begin
                        state <= ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_WAIT_LOCK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign state_o = state;

`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    // Saturating count of RUN -> WAIT_LOCK transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if ((state == ST_RUN) && !lock_s && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_CNT_W'(1);
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with short windows (4 stable, 2 hold).
module tb_pll_reset_sequencer;

    localparam int unsigned LSC  = 4;
    localparam int unsigned HC   = 2;
    localparam int unsigned LW   = 2;
`ifdef PLL_RST_SEQ_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    typedef struct packed {
        logic       sys_rst;
        logic       ready;
        logic [1:0] st;
        logic [1:0] loss;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_lock = 1'b0;
    logic          sys_rst;
    logic          ready;
    logic [1:0]    state_o;
    logic [LW-1:0] loss_count;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .HOLD_CYCLES        (HC),
        .LOSS_CNT_W         (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .state_o    (state_o),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    // Expected state after the k-th edge that samples a steady high lock, starting from WAIT_LOCK
    // with cleared synchroniser: 2 edges of sync, LSC in STABLE, HC in HOLD, then RUN.
    function automatic logic [1:0] clean_st(input int k);
        if (k < 2)                  return 2'd0;
        else if (k < 2 + LSC)       return 2'd1;
        else if (k < 2 + LSC + HC)  return 2'd2;
        else                        return 2'd3;
    endfunction

    function automatic logic [1:0] loss_exp(input int n);
        if (!LOSS_EN) return 2'd0;
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    function automatic obs_t mk(input logic [1:0] st, input logic [1:0] loss);
        obs_t o;
        o.sys_rst = (st != 2'd3);
        o.ready   = (st == 2'd3);
        o.st      = st;
        o.loss    = loss;
        return o;
    endfunction

    function automatic obs_t sample();
        return {sys_rst, ready, state_o, loss_count};
    endfunction

    // Drive one lock value for the next rising edge and settle just after it.
    task automatic step(input logic lock);
        @(negedge clk);
        pll_lock = lock;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst(input logic lock);
        rst      = 1'b1;
        pll_lock = lock;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, e;
        rst      = 1'b1;
        pll_lock = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(2'd0, 2'd0));
            @(posedge clk);
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL reset k=%0d got=%h exp=%h", k, got, e);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        obs_t got, e;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(mk(clean_st(k), 2'd0));
            step(1'b1);
            got = sample();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL clean_lock k=%0d got=%h exp=%h", k, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_glitch_stable();
        obs_t got, e;
        logic lk;
        apply_rst(1'b0);
        for (int k = 0; k < 14; k++) begin
            lk = (k != 3);
            exp_q.push_back(mk((k < 5) ? clean_st(k) : clean_st(k - 4), 2'd0));
            step(lk);
            got = sample();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL glitch_stable k=%0d got=%h exp=%h", k, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_loss_in_run();
        obs_t got, e;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                exp_q.push_back((k < 2) ? mk(2'd3, loss_exp(i)) : mk(2'd0, loss_exp(i + 1)));
                step(1'b0);
                got = sample();
                e   = exp_q.pop_front();
                n_checks++;
                if (got !== e) $display("FAIL loss_drop i=%0d k=%0d got=%h exp=%h", i, k, got, e);
                else n_pass++;
            end
            for (int k = 0; k < 10; k++) begin
                exp_q.push_back(mk(clean_st(k), loss_exp(i + 1)));
                step(1'b1);
                got = sample();
                e   = exp_q.pop_front();
                n_checks++;
                if (got !== e) $display("FAIL loss_relock i=%0d k=%0d got=%h exp=%h", i, k, got, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_rst_hold();
        obs_t got, e;
        apply_rst(1'b0);
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(mk(clean_st(k), 2'd0));
            step(1'b1);
            got = sample();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL async_pre k=%0d got=%h exp=%h", k, got, e);
            else n_pass++;
        end
        // Mid-cycle pulse: the reset must take effect with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(2'd0, 2'd0));
        got = sample();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL async_immediate got=%h exp=%h", got, e);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(mk(clean_st(k), 2'd0));
            step(1'b1);
            got = sample();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL async_reseq k=%0d got=%h exp=%h", k, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_lock_at_release();
        obs_t got, e;
        apply_rst(1'b1);
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(mk(clean_st(k), 2'd0));
            step(1'b1);
            got = sample();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL lock_at_release k=%0d got=%h exp=%h", k, got, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch_stable();
        test_loss_in_run();
        test_async_rst_hold();
        test_lock_at_release();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
